uart_fifo_core: RTL and testbench

Parametrised UART core: the successor to the single-buffer 8-bit UART. It adds configurable data width, TX and RX FIFOs, 16x-oversampled RX with error detection, selectable parity and stop bits, and separate TX/RX baud dividers. It sits behind the ICB register strobes like the existing UART and drives the pad-level `uart_tx` / `uart_rx` lines. Everything runs in one clock domain.

---
 rtl/uart_fifo_core.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// UART core with TX/RX FIFOs, 16x-oversampled receiver, optional parity and two stop bits.
// Single clock domain. Register strobes come from the ICB decode, as in the 8-bit UART.
module uart_fifo_core #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              uart_con_wr,
    input  logic              uart_baud_wr,
    input  logic              uart_txbuf_wr,
    input  logic              uart_rxbuf_rd,
    input  logic [15:0]       icb_wdat,
    output logic [15:0]       uart_con,
    output logic [BAUD_W-1:0] uart_baud,
    output logic [15:0]       uart_rxbuf,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              uart_int
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [3:0]        LAST_BIT = 4'(DATA_W - 1);
    localparam logic [AW:0]       PTR_ONE  = 1;
    localparam logic [BAUD_W-1:0] BAUD_ONE = 1;

    // Control / status registers
    logic              en, txie, rxie, prty_en, prty_odd, stop2;
    logic              ovf, frame_err, prty_err;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_wval;
    logic              en_nxt;
    logic              flush;

    // TX FIFO
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wp, tx_rp;
    logic              tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;

    // TX FSM
    logic [2:0]        tx_state;
    logic [BAUD_W-1:0] tx_bcnt;
    logic [3:0]        tx_tcnt;
    logic [3:0]        tx_bit;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_par;
    logic              tx_line;
    logic              tx_tick, tx_bit_end, tx_load;

    // RX input path and FSM
    logic              rx_s1, rx_s2, rx_d;
    logic              rx_fall;
    logic [2:0]        rx_state;
    logic [BAUD_W-1:0] rx_bcnt;
    logic [3:0]        rx_tcnt;
    logic [3:0]        rx_bit;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_perr;
    logic              rx_tick, rx_sample, rx_stop_smp, rx_good;

    // RX FIFO
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       rx_wp, rx_rp;
    logic              rx_empty, rx_full, rx_push, rx_pop;
    logic              ovf_set, ferr_set, perr_set;
    logic [15:0]       rxbuf_val;
    logic              txpnd, rxpnd;

    assign baud_wval = BAUD_W'(icb_wdat);
    // Disabling takes effect on the same edge that commits en=0, so the line is idle one cycle after the write.
    assign en_nxt    = uart_con_wr ? icb_wdat[0] : en;
    assign flush     = ~en_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            en        <= 1'b0;
            txie      <= 1'b0;
            rxie      <= 1'b0;
            prty_en   <= 1'b0;
            prty_odd  <= 1'b0;
            stop2     <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
            prty_err  <= 1'b0;
            baud      <= '0;
        end else begin
            if (uart_con_wr) begin
                en       <= icb_wdat[0];
                txie     <= icb_wdat[1];
                rxie     <= icb_wdat[2];
                prty_en  <= icb_wdat[3];
                prty_odd <= icb_wdat[4];
                stop2    <= icb_wdat[5];
            end
            if (uart_baud_wr)
                baud <= baud_wval;
            if (uart_con_wr && icb_wdat[10]) begin
                ovf       <= 1'b0;
                frame_err <= 1'b0;
                prty_err  <= 1'b0;
            end
            // A new error event in the same cycle as a clear is kept
            if (ovf_set)
                ovf <= 1'b1;
            if (ferr_set)
                frame_err <= 1'b1;
            if (perr_set)
                prty_err <= 1'b1;
        end
    end

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    assign tx_pop   = tx_load;
    assign tx_push  = uart_txbuf_wr && en && (!tx_full || tx_pop);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)
                tx_rp <= tx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (tx_push)
            tx_mem[tx_wp[AW-1:0]] <= icb_wdat[DATA_W-1:0];
    end

    assign tx_tick    = (tx_bcnt >= baud);
    assign tx_bit_end = tx_tick && (tx_tcnt == 4'd15);

    always_comb begin
        tx_load = 1'b0;
        case (tx_state)
            ST_IDLE: tx_load = en && !tx_empty;
            ST_STOP: tx_load = tx_bit_end && !(stop2 && tx_bit == 4'd0) && en && !tx_empty;
            default: tx_load = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            tx_state <= ST_IDLE;
            tx_bcnt  <= '0;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_bcnt <= tx_tick ? '0 : tx_bcnt + BAUD_ONE;
            if (tx_tick)
                tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_load) begin
                // Divider restarts so the start bit is a full 16 ticks long
                tx_state <= ST_START;
                tx_line  <= 1'b0;
                tx_sh    <= tx_head;
                tx_par   <= (^tx_head) ^ prty_odd;
                tx_bcnt  <= '0;
                tx_tcnt  <= '0;
                tx_bit   <= '0;
            end else if (tx_bit_end) begin
                case (tx_state)
                    ST_START: begin
                        tx_state <= ST_DATA;
                        tx_line  <= tx_sh[0];
                        tx_bit   <= '0;
                    end
                    ST_DATA: begin
                        if (tx_bit == LAST_BIT) begin
                            tx_bit <= '0;
                            if (prty_en) begin
                                tx_state <= ST_PAR;
                                tx_line  <= tx_par;
                            end else begin
                                tx_state <= ST_STOP;
                                tx_line  <= 1'b1;
                            end
                        end else begin
                            tx_bit  <= tx_bit + 4'd1;
                            tx_sh   <= tx_sh >> 1;
                            tx_line <= tx_sh[1];
                        end
                    end
                    ST_PAR: begin
                        tx_state <= ST_STOP;
                        tx_line  <= 1'b1;
                        tx_bit   <= '0;
                    end
                    ST_STOP: begin
                        if (stop2 && tx_bit == 4'd0) begin
                            tx_bit <= 4'd1;
                        end else begin
                            tx_state <= ST_IDLE;
                            tx_line  <= 1'b1;
                        end
                    end
                    default: tx_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Two-flop synchroniser plus a delay flop for falling-edge detection
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall     = rx_d & ~rx_s2;
    assign rx_tick     = (rx_bcnt >= baud);
    assign rx_sample   = rx_tick && (rx_tcnt == 4'd7) && (rx_state != ST_IDLE);
    assign rx_stop_smp = rx_sample && (rx_state == ST_STOP);
    assign rx_good     = rx_stop_smp && rx_s2 && !rx_perr;
    assign ferr_set    = rx_stop_smp && !rx_s2;
    assign perr_set    = rx_stop_smp && rx_perr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            rx_state <= ST_IDLE;
            rx_bcnt  <= '0;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_bcnt <= rx_tick ? '0 : rx_bcnt + BAUD_ONE;
            if (rx_tick)
                rx_tcnt <= rx_tcnt + 4'd1;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= ST_START;
                        rx_bcnt  <= '0;
                        rx_tcnt  <= '0;
                        rx_perr  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (rx_sample) begin
                        rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                        rx_bit   <= '0;
                    end
                end
                ST_DATA: begin
                    if (rx_sample) begin
                        rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
                        if (rx_bit == LAST_BIT) begin
                            rx_state <= prty_en ? ST_PAR : ST_STOP;
                            rx_bit   <= '0;
                        end else begin
                            rx_bit <= rx_bit + 4'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (rx_sample) begin
                        rx_perr  <= (rx_s2 != ((^rx_sh) ^ prty_odd));
                        rx_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Only the first stop bit is checked; return at once to catch the next edge
                    if (rx_sample)
                        rx_state <= ST_IDLE;
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop   = uart_rxbuf_rd && !rx_empty;
    assign rx_push  = rx_good && (!rx_full || rx_pop);
    assign ovf_set  = rx_good && rx_full && !rx_pop;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)
                rx_rp <= rx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rx_push)
            rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_comb begin
        rxbuf_val = '0;
        if (!rx_empty)
            rxbuf_val[DATA_W-1:0] = rx_mem[rx_rp[AW-1:0]];
    end

    assign txpnd      = tx_empty && (tx_state == ST_IDLE);
    assign rxpnd      = !rx_empty;
    assign uart_con   = {txpnd, rxpnd, tx_full, tx_empty, 3'b000,
                         prty_err, frame_err, ovf,
                         stop2, prty_odd, prty_en, rxie, txie, en};
    assign uart_baud  = baud;
    assign uart_rxbuf = rxbuf_val;
    assign uart_tx    = tx_line;
    assign uart_int   = en & ((txie & txpnd) | (rxie & (rxpnd | ovf | frame_err | prty_err)));

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: TX framing, RX loopback, RX errors, overflow, disable and reset.
module tb_uart_fifo_core;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_con_wr = 1'b0;
    logic        uart_baud_wr = 1'b0;
    logic        uart_txbuf_wr = 1'b0;
    logic        uart_rxbuf_rd = 1'b0;
    logic [15:0] icb_wdat = '0;
    logic [15:0] uart_con;
    logic [15:0] uart_baud;
    logic [15:0] uart_rxbuf;
    logic        uart_rx;
    logic        uart_tx;
    logic        uart_int;
    logic        loopback = 1'b0;
    logic        rx_man = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    assign uart_rx = loopback ? uart_tx : rx_man;

    always #5 sys_clk = ~sys_clk;

    uart_fifo_core #(.DATA_W(8), .FIFO_DEPTH(4), .BAUD_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .uart_con_wr(uart_con_wr), .uart_baud_wr(uart_baud_wr),
        .uart_txbuf_wr(uart_txbuf_wr), .uart_rxbuf_rd(uart_rxbuf_rd),
        .icb_wdat(icb_wdat), .uart_con(uart_con), .uart_baud(uart_baud),
        .uart_rxbuf(uart_rxbuf), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .uart_int(uart_int)
    );

    task automatic do_reset();
        sys_rst = 1'b1; uart_con_wr = 0; uart_baud_wr = 0; uart_txbuf_wr = 0;
        uart_rxbuf_rd = 0; icb_wdat = '0; loopback = 0; rx_man = 1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic wr_con(input logic [15:0] v);
        icb_wdat = v; uart_con_wr = 1'b1; @(negedge sys_clk); uart_con_wr = 1'b0;
    endtask

    task automatic wr_baud(input logic [15:0] v);
        icb_wdat = v; uart_baud_wr = 1'b1; @(negedge sys_clk); uart_baud_wr = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] v);
        icb_wdat = {8'h00, v}; uart_txbuf_wr = 1'b1; @(negedge sys_clk); uart_txbuf_wr = 1'b0;
    endtask

    task automatic rd_rx();
        uart_rxbuf_rd = 1'b1; @(negedge sys_clk); uart_rxbuf_rd = 1'b0;
    endtask

    task automatic rx_bits(input logic v, input int n);
        rx_man = v; repeat (n) @(negedge sys_clk);
    endtask

    // One manually driven 8-bit frame at baud=3 (64 cycles per bit), followed by one idle bit
    task automatic send_rx(input logic [7:0] d, input logic pe, input logic pv, input logic sv);
        rx_bits(1'b0, 64);
        for (int i = 0; i < 8; i++) rx_bits(d[i], 64);
        if (pe) rx_bits(pv, 64);
        rx_bits(sv, 64);
        rx_bits(1'b1, 64);
    endtask

    task automatic wait_txpnd(input int limit, input string name);
        int t;
        t = 0;
        while (t < limit && uart_con[15] !== 1'b1) begin
            @(negedge sys_clk);
            t++;
        end
        n_checks++;
        if (uart_con[15] !== 1'b1) begin
            n_fail++; $display("FAIL %s timeout: txpnd=%b required 1", name, uart_con[15]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (uart_con !== 16'h9000) begin n_fail++; $display("FAIL reset_con got %h want 9000", uart_con); end
        n_checks++; if (uart_baud !== 16'h0000) begin n_fail++; $display("FAIL reset_baud got %h want 0000", uart_baud); end
        n_checks++; if (uart_rxbuf !== 16'h0000) begin n_fail++; $display("FAIL reset_rxbuf got %h want 0000", uart_rxbuf); end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", uart_tx); end
        n_checks++; if (uart_int !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b want 0", uart_int); end
    endtask

    task automatic test_tx_8n1();
        logic [7:0] d;
        logic e;
        int b;
        do_reset();
        wr_con(16'h0001);
        n_checks++; if (uart_con !== 16'h9001) begin n_fail++; $display("FAIL con_write got %h want 9001", uart_con); end
        wr_baud(16'h0000);
        d = 8'h55;
        push_tx(d);
        n_checks++; if (uart_con[12] !== 1'b0) begin n_fail++; $display("FAIL tx8n1_nonempty tx_empty=%b want 0", uart_con[12]); end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx8n1_n1 tx=%b want 1", uart_tx); end
        @(negedge sys_clk);
        for (int i = 2; i <= 161; i++) begin
            b = (i - 2) / 16;
            e = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : 1'b1;
            n_checks++;
            if (uart_tx !== e) begin n_fail++; $display("FAIL tx8n1_bit cyc N+%0d tx=%b want %b", i, uart_tx, e); end
            @(negedge sys_clk);
        end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx8n1_idle tx=%b want 1", uart_tx); end
        n_checks++; if (uart_con[15] !== 1'b1) begin n_fail++; $display("FAIL tx8n1_txpnd got %b want 1", uart_con[15]); end
    endtask

    task automatic test_tx_8o2_back_to_back();
        logic [7:0] dat [0:4];
        logic e;
        int j, f, p;
        dat[0] = 8'h03; dat[1] = 8'hFF; dat[2] = 8'h81; dat[3] = 8'h01; dat[4] = 8'h7F;
        do_reset();
        wr_baud(16'h0000);
        wr_con(16'h0039);
        for (int i = 0; i < 5; i++) push_tx(dat[i]);
        n_checks++; if (uart_con[13] !== 1'b1) begin n_fail++; $display("FAIL tx_full got %b want 1", uart_con[13]); end
        push_tx(8'h3C);
        n_checks++; if (uart_con[13] !== 1'b1) begin n_fail++; $display("FAIL tx_full_after_drop got %b want 1", uart_con[13]); end
        for (int i = 6; i <= 961; i++) begin
            j = (i - 2) / 16; f = j / 12; p = j % 12;
            if (p == 0) e = 1'b0;
            else if (p <= 8) e = dat[f][p-1];
            else if (p == 9) e = ~(^dat[f]);
            else e = 1'b1;
            n_checks++;
            if (uart_tx !== e) begin n_fail++; $display("FAIL tx8o2_bit cyc N+%0d frame %0d pos %0d tx=%b want %b", i, f, p, uart_tx, e); end
            @(negedge sys_clk);
        end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx8o2_idle tx=%b want 1", uart_tx); end
        n_checks++; if (uart_con[15] !== 1'b1) begin n_fail++; $display("FAIL tx8o2_txpnd got %b want 1 (dropped push sent?)", uart_con[15]); end
    endtask

    task automatic test_rx_loopback();
        do_reset();
        loopback = 1'b1;
        wr_baud(16'h0003);
        wr_con(16'h0001);
        push_tx(8'hA5);
        push_tx(8'h3C);
        wait_txpnd(4000, "loop_wait");
        repeat (10) @(negedge sys_clk);
        n_checks++; if (uart_con[14] !== 1'b1) begin n_fail++; $display("FAIL loop_rxpnd got %b want 1", uart_con[14]); end
        n_checks++; if (uart_rxbuf !== 16'h00A5) begin n_fail++; $display("FAIL loop_first got %h want 00A5", uart_rxbuf); end
        rd_rx();
        n_checks++; if (uart_rxbuf !== 16'h003C) begin n_fail++; $display("FAIL loop_second got %h want 003C", uart_rxbuf); end
        rd_rx();
        n_checks++; if (uart_rxbuf !== 16'h0000) begin n_fail++; $display("FAIL loop_empty got %h want 0000", uart_rxbuf); end
        n_checks++; if (uart_con[14] !== 1'b0) begin n_fail++; $display("FAIL loop_rxpnd_clr got %b want 0", uart_con[14]); end
        n_checks++; if (uart_con[8:6] !== 3'b000) begin n_fail++; $display("FAIL loop_flags got %b want 000", uart_con[8:6]); end
    endtask

    task automatic test_rx_errors();
        do_reset();
        wr_baud(16'h0003);
        wr_con(16'h0001);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        n_checks++; if (uart_con[8:6] !== 3'b010) begin n_fail++; $display("FAIL frame_err flags got %b want 010", uart_con[8:6]); end
        n_checks++; if (uart_con[14] !== 1'b0) begin n_fail++; $display("FAIL frame_err_discard rxpnd=%b want 0", uart_con[14]); end
        wr_con(16'h0401);
        n_checks++; if (uart_con[8:6] !== 3'b000) begin n_fail++; $display("FAIL w1c flags got %b want 000", uart_con[8:6]); end
        wr_con(16'h0009);
        send_rx(8'h5A, 1'b1, 1'b1, 1'b1);
        n_checks++; if (uart_con[8:6] !== 3'b100) begin n_fail++; $display("FAIL prty_err flags got %b want 100", uart_con[8:6]); end
        n_checks++; if (uart_con[14] !== 1'b0) begin n_fail++; $display("FAIL prty_err_discard rxpnd=%b want 0", uart_con[14]); end
        wr_con(16'h0409);
        send_rx(8'h5A, 1'b1, 1'b0, 1'b1);
        n_checks++; if (uart_rxbuf !== 16'h005A) begin n_fail++; $display("FAIL even_parity_ok got %h want 005A", uart_rxbuf); end
        n_checks++; if (uart_con[8:6] !== 3'b000) begin n_fail++; $display("FAIL good_frame_flags got %b want 000", uart_con[8:6]); end
        rd_rx();
        rx_bits(1'b0, 4);
        rx_bits(1'b1, 200);
        n_checks++; if (uart_con[8:6] !== 3'b000) begin n_fail++; $display("FAIL glitch_flags got %b want 000", uart_con[8:6]); end
        n_checks++; if (uart_con[14] !== 1'b0) begin n_fail++; $display("FAIL glitch_rxpnd got %b want 0", uart_con[14]); end
        send_rx(8'h33, 1'b1, 1'b0, 1'b1);
        n_checks++; if (uart_rxbuf !== 16'h0033) begin n_fail++; $display("FAIL after_glitch got %h want 0033", uart_rxbuf); end
        rd_rx();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
        do_reset();
        loopback = 1'b1;
        wr_baud(16'h0000);
        wr_con(16'h0005);
        n_checks++; if (uart_int !== 1'b0) begin n_fail++; $display("FAIL ovf_int_idle got %b want 0", uart_int); end
        for (int i = 1; i <= 5; i++) push_tx(8'(i * 17));
        wait_txpnd(3000, "ovf_wait");
        repeat (20) @(negedge sys_clk);
        n_checks++; if (uart_con[6] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", uart_con[6]); end
        n_checks++; if (uart_int !== 1'b1) begin n_fail++; $display("FAIL ovf_int got %b want 1", uart_int); end
        for (int i = 1; i <= 4; i++) begin
            exp_d = 8'(i * 17);
            n_checks++;
            if (uart_rxbuf !== {8'h00, exp_d}) begin n_fail++; $display("FAIL ovf_entry%0d got %h want %h", i, uart_rxbuf, {8'h00, exp_d}); end
            rd_rx();
        end
        n_checks++; if (uart_con[14] !== 1'b0) begin n_fail++; $display("FAIL ovf_drained rxpnd=%b want 0", uart_con[14]); end
        n_checks++; if (uart_int !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_int got %b want 1", uart_int); end
        wr_con(16'h0405);
        n_checks++; if (uart_int !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_int got %b want 0", uart_int); end
    endtask

    task automatic test_disable_reset();
        do_reset();
        loopback = 1'b1;
        wr_baud(16'h0000);
        wr_con(16'h0001);
        push_tx(8'hAA);
        wait_txpnd(1000, "dis_wait");
        repeat (5) @(negedge sys_clk);
        n_checks++; if (uart_con[14] !== 1'b1) begin n_fail++; $display("FAIL dis_pre_rxpnd got %b want 1", uart_con[14]); end
        push_tx(8'hBB);
        push_tx(8'hCC);
        repeat (40) @(negedge sys_clk);
        wr_con(16'h0000);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL dis_tx got %b want 1", uart_tx); end
        n_checks++; if (uart_con !== 16'h9000) begin n_fail++; $display("FAIL dis_con got %h want 9000", uart_con); end
        n_checks++; if (uart_rxbuf !== 16'h0000) begin n_fail++; $display("FAIL dis_rxbuf got %h want 0000", uart_rxbuf); end
        repeat (20) @(negedge sys_clk);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL dis_tx_hold got %b want 1", uart_tx); end
        loopback = 1'b0;
        wr_baud(16'h0003);
        wr_con(16'h0007);
        rx_man = 1'b0;
        repeat (100) @(negedge sys_clk);
        sys_rst = 1'b1;
        rx_man = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        n_checks++; if (uart_con !== 16'h9000) begin n_fail++; $display("FAIL rst_mid_con got %h want 9000", uart_con); end
        n_checks++; if (uart_baud !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_baud got %h want 0000", uart_baud); end
        n_checks++; if (uart_int !== 1'b0) begin n_fail++; $display("FAIL rst_mid_int got %b want 0", uart_int); end
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_tx_8o2_back_to_back();
        test_rx_loopback();
        test_rx_errors();
        test_overflow();
        test_disable_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
